// File: rtl/mem_wb_pkg.sv
// ============================================================================
// Module : mem_wb_pkg
// Brief  : Shared FSM state encoding and default error read-data for mem_wb_bridge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_wb_pkg;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_WBSTART = 2'd1;
    localparam logic [1:0] c_ST_WBEND   = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = c_ST_IDLE,
        WBSTART = c_ST_WBSTART,
        WBEND   = c_ST_WBEND
    } state_e;

    // Wide enough for the largest legal DATA_W; the bridge slices it down.
    localparam logic [63:0] c_ERR_RDATA_DFLT = '1;

endpackage

`default_nettype wire

// File: rtl/mem_wb_timeout.sv
// ============================================================================
// Module : mem_wb_timeout
// Brief  : 16-bit WBSTART cycle counter; flags the cycle that reaches TIMEOUT_CYC.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_wb_timeout #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [15:0] c_LIMIT = 16'(TIMEOUT_CYC);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    assign cnt_d     = cnt_q + 16'd1;
    // Asserted during the WBSTART cycle whose closing edge would bring the count to the limit.
    assign expired_o = enable_i && (cnt_d == c_LIMIT);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q <= 16'd0;
        end else if (enable_i) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_wb_bridge.sv
// ============================================================================
// Module : mem_wb_bridge
// Brief  : Native memory request to single-beat Wishbone master bridge.
//          Optional WBSTART timeout enabled by MEM_WB_BRIDGE_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_wb_bridge
    import mem_wb_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       TIMEOUT_CYC = 255,
    parameter logic [DATA_W-1:0] ERR_RDATA   = c_ERR_RDATA_DFLT[DATA_W-1:0]
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  mem_valid,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W/8-1:0]   mem_wstrb,
    output logic                  mem_ready,
    output logic [DATA_W-1:0]     mem_rdata,
    output logic                  mem_err,
    output logic [ADDR_W-1:0]     wbm_adr_o,
    output logic [DATA_W-1:0]     wbm_dat_o,
    output logic                  wbm_we_o,
    output logic [DATA_W/8-1:0]   wbm_sel_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_cyc_o,
    input  logic [DATA_W-1:0]     wbm_dat_i,
    input  logic                  wbm_ack_i,
    input  logic                  wbm_err_i,
    output logic [7:0]            err_count
);

    state_e                state_q;
    logic [ADDR_W-1:0]     adr_q;
    logic [DATA_W-1:0]     dat_q;
    logic [DATA_W/8-1:0]   sel_q;
    logic                  we_q;
    logic                  stb_q;
    logic                  cyc_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  ready_q;
    logic                  err_q;
    logic [7:0]            err_cnt_q;

    logic                  w_start;
    logic                  w_in_wbstart;
    logic                  w_tmo_expired;

    assign w_start      = (state_q == IDLE) && mem_valid;
    assign w_in_wbstart = (state_q == WBSTART);

`ifdef MEM_WB_BRIDGE_TIMEOUT_EN
    mem_wb_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .clear_i   (w_start),
        .enable_i  (w_in_wbstart),
        .expired_o (w_tmo_expired)
    );
`else
    logic w_unused_tmo;
    assign w_unused_tmo  = ^{16'(TIMEOUT_CYC), w_in_wbstart};
    assign w_tmo_expired = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            stb_q     <= 1'b0;
            cyc_q     <= 1'b0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_start) begin
                        adr_q   <= mem_addr;
                        dat_q   <= mem_wdata;
                        we_q    <= |mem_wstrb;
                        sel_q   <= (|mem_wstrb) ? mem_wstrb : '1;
                        stb_q   <= 1'b1;
                        cyc_q   <= 1'b1;
                        state_q <= WBSTART;
                    end
                end
                WBSTART: begin
                    // A bus error outranks ack; ack outranks a timeout in the same cycle.
                    if (wbm_err_i || (!wbm_ack_i && w_tmo_expired)) begin
                        stb_q     <= 1'b0;
                        cyc_q     <= 1'b0;
                        we_q      <= 1'b0;
                        rdata_q   <= ERR_RDATA;
                        ready_q   <= 1'b1;
                        err_q     <= 1'b1;
                        state_q   <= WBEND;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_q <= err_cnt_q + 8'd1;
                        end
                    end else if (wbm_ack_i) begin
                        stb_q   <= 1'b0;
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        rdata_q <= wbm_dat_i;
                        ready_q <= 1'b1;
                        err_q   <= 1'b0;
                        state_q <= WBEND;
                    end
                end
                WBEND: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    stb_q   <= 1'b0;
                    cyc_q   <= 1'b0;
                    we_q    <= 1'b0;
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_stb_o = stb_q;
    assign wbm_cyc_o = cyc_q;
    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign mem_err   = err_q;
    assign err_count = err_cnt_q;

endmodule

`default_nettype wire

// File: doc/mem_wb_bridge.md
MEM_WB_BRIDGE -- requirements
Module: mem_wb_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; legal values 32 or 64; SEL_W = DATA_W/8.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, maximum cycles in WBSTART before forced abort; legal range 1..65535.
REQ-004 SHALL have parameter ERR_RDATA, default all ones (DATA_W bits), value returned on mem_rdata for an errored read.
REQ-005 SHALL have port wb_clk_i, in, 1, sole clock, all logic on rising edge.
REQ-006 SHALL have port wb_rst_i, in, 1, synchronous active-high reset.
REQ-007 SHALL have ports mem_valid in 1, mem_addr in ADDR_W, mem_wdata in DATA_W, mem_wstrb in SEL_W, forming the native core request.
REQ-008 SHALL have ports mem_ready out 1, mem_rdata out DATA_W, mem_err out 1, forming the native response.
REQ-009 SHALL have ports wbm_adr_o out ADDR_W, wbm_dat_o out DATA_W, wbm_we_o out 1, wbm_sel_o out SEL_W, wbm_stb_o out 1, wbm_cyc_o out 1, all registered.
REQ-010 SHALL have ports wbm_dat_i in DATA_W, wbm_ack_i in 1, wbm_err_i in 1.
REQ-011 SHALL have port err_count, out, 8, saturating count of errored transactions.

Function
REQ-012 SHALL implement FSM IDLE, WBSTART, WBEND; encoding 2 bits; illegal encoding -> IDLE.
REQ-013 IDLE with mem_valid=1 SHALL, at that edge, latch adr/dat/wstrb, set stb=cyc=1, we = OR of mem_wstrb, and go to WBSTART.
REQ-014 For reads (mem_wstrb==0) wbm_sel_o SHALL be all ones; for writes wbm_sel_o SHALL equal mem_wstrb.
REQ-015 In WBSTART, wbm_adr_o/dat_o/sel_o/we_o SHALL hold stable; mem_valid changes SHALL be ignored.
REQ-016 WBSTART with wbm_ack_i=1 and wbm_err_i=0 SHALL capture wbm_dat_i into mem_rdata, drop stb/cyc/we, and go to WBEND with mem_ready=1, mem_err=0.
REQ-017 WBSTART with wbm_err_i=1 SHALL drop stb/cyc/we, load mem_rdata=ERR_RDATA, go to WBEND with mem_ready=1, mem_err=1; err wins over simultaneous ack.
REQ-018 WBEND SHALL last exactly one cycle, then clear mem_ready and mem_err and go to IDLE; mem_valid during WBEND SHALL NOT start a new cycle.
REQ-019 Minimum latency SHALL be: request sampled edge N, stb high after N, ack sampled edge N+1, mem_ready high for cycle after N+1 only; back-to-back request earliest at edge N+3.
REQ-020 err_count SHALL increment by 1 on each entry into WBEND with mem_err=1 and saturate at 255.
REQ-021 mem_rdata SHALL hold its last value outside WBEND.

Reset
REQ-022 wb_rst_i=1 SHALL force state=IDLE, all wbm_* outputs 0, mem_ready=0, mem_err=0, mem_rdata=0, err_count=0, timeout counter=0, at the next edge regardless of state.
REQ-023 Reset during WBSTART SHALL abandon the bus cycle without asserting mem_ready.

Configuration
REQ-024 Macro MEM_WB_BRIDGE_TIMEOUT_EN defined SHALL add a 16-bit counter cleared on WBSTART entry, incrementing each WBSTART cycle; reaching TIMEOUT_CYC without ack/err SHALL abort exactly as REQ-017.
REQ-025 Macro undefined SHALL remove the counter; WBSTART waits indefinitely; TIMEOUT_CYC unused.

Structure
REQ-026 State encoding localparams and default ERR_RDATA SHALL live in shared package mem_wb_pkg.
REQ-027 Timeout counter SHALL be sub-module mem_wb_timeout (inputs clear, enable; output expired); no other sub-modules.

Verification
REQ-028 Read: mem_valid, addr 0x0000_1000, wstrb 0; slave acks 1 cycle later with 0xCAFE_F00D -> sel=0xF, we=0, mem_rdata=0xCAFE_F00D, mem_ready 1 cycle, mem_err=0.
REQ-029 Write: addr 0x10, wdata 0x1234_5678, wstrb 0b0011; ack after 3 waits -> we=1, sel=0x3, dat stable all WBSTART cycles, one mem_ready pulse.
REQ-030 Error: ack and err both high same cycle on read -> mem_err=1, mem_rdata=0xFFFF_FFFF, err_count 0->1.
REQ-031 Timeout (macro on, TIMEOUT_CYC=4): no ack -> abort after 4 WBSTART cycles, mem_err=1; macro off, 100 cycles no ack -> stb still 1.
REQ-032 Reset mid-WBSTART -> next cycle stb=cyc=0, mem_ready never asserted, err_count=0.
REQ-033 Saturation: 260 errored transactions -> err_count=255.
